// File: rtl/neurocam_cmd_assembler.sv
// NeuroCAM front-end: assembles nibble-serial search/write frames into one parallel command word,
// rejecting bad opcodes and abandoning frames that stall for TIMEOUT_CYCLES.
module neurocam_cmd_assembler #(
  parameter int unsigned PATTERN_WIDTH  = 12,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nib_valid,
  input  logic [3:0]               nib_data,
  output logic                     nib_ready,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_write,
  output logic [ADDR_WIDTH-1:0]    cmd_addr,
  output logic [PATTERN_WIDTH-1:0] cmd_data,
  output logic                     err_pulse,
  output logic [1:0]               err_code,
  output logic [CNT_WIDTH-1:0]     cmd_count
);

  localparam int unsigned NIBS  = PATTERN_WIDTH / 4;
  localparam int unsigned IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NIBS - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StHold} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             xfer;

  assign xfer = nib_valid && nib_ready;

  // cmd_write/cmd_addr/cmd_data double as the assembly shadow registers; they only change
  // outside HOLD, so they are stable for the whole time cmd_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      to_cnt_q  <= '0;
      nib_ready <= 1'b1;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      err_pulse <= 1'b0;
      err_code  <= 2'b00;
      cmd_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            if (nib_data == 4'h1 || nib_data == 4'h2) begin
              state_q   <= (nib_data == 4'h1) ? StData : StAddr;
              cmd_write <= (nib_data == 4'h2);
              cmd_addr  <= '0;
              cmd_data  <= '0;
              idx_q     <= '0;
              to_cnt_q  <= '0;
            end else begin
              err_pulse <= 1'b1;
              err_code  <= 2'b01;
            end
          end
        end
        StAddr: begin
          if (xfer) begin
            cmd_addr <= ADDR_WIDTH'(nib_data);
            to_cnt_q <= '0;
            state_q  <= StData;
          end
        end
        StData: begin
          if (xfer) begin
            cmd_data[idx_q*4 +: 4] <= nib_data;
            to_cnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q   <= StHold;
              cmd_valid <= 1'b1;
              nib_ready <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_count <= cmd_count + 1'b1;
            nib_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Stall timer; a transfer in the limit cycle is handled above and never reaches here.
      if ((state_q == StAddr || state_q == StData) && !xfer) begin
        if (to_cnt_q == TO_LAST) begin
          to_cnt_q  <= '0;
          state_q   <= StIdle;
          err_pulse <= 1'b1;
          err_code  <= 2'b10;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_neurocam_cmd_assembler.sv
// Directed bench for neurocam_cmd_assembler; completed commands are checked against a scoreboard.
module tb_neurocam_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nib_valid;
  logic [3:0]  nib_data;
  logic        nib_ready;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [11:0] cmd_data;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [7:0]  cmd_count;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        w;
    logic [3:0]  a;
    logic [11:0] d;
  } exp_t;

  exp_t exp_q[$];

  neurocam_cmd_assembler #(
    .PATTERN_WIDTH (12),
    .ADDR_WIDTH    (4),
    .TIMEOUT_CYCLES(4),
    .CNT_WIDTH     (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .nib_valid(nib_valid),
    .nib_data (nib_data),
    .nib_ready(nib_ready),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .err_pulse(err_pulse),
    .err_code (err_code),
    .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_nib(input logic [3:0] d);
    int n = 0;
    while (!nib_ready && n < 20) begin
      tick();
      n++;
    end
    if (!nib_ready) check("nib_ready_wait", {31'b0, nib_ready}, 32'd1);
    nib_valid = 1'b1;
    nib_data  = d;
    tick();
    nib_valid = 1'b0;
  endtask

  task automatic send_search(input logic [11:0] d);
    exp_q.push_back('{w: 1'b0, a: 4'h0, d: d});
    send_nib(4'h1);
    send_nib(d[3:0]);
    send_nib(d[7:4]);
    send_nib(d[11:8]);
  endtask

  // Scoreboard: every handshake must match the oldest outstanding expected command.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      exp_t got;
      got = '{w: cmd_write, a: cmd_addr, d: cmd_data};
      checks++;
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          failures++;
          $error("FAIL sb_unexpected observed=%0h expected=none", got);
        end
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        assert (got === e) else begin
          failures++;
          $error("FAIL sb_cmd observed=%0h expected=%0h", got, e);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    nib_valid = 1'b0;
    nib_data  = 4'h0;
    cmd_ready = 1'b0;
    #12;
    check("rst_nib_ready", {31'b0, nib_ready}, 32'd1);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 32'd0);
    check("rst_cmd_data", {20'b0, cmd_data}, 32'd0);
    check("rst_err_code", {30'b0, err_code}, 32'd0);
    check("rst_cmd_count", {24'b0, cmd_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Search frame, ready already high
    cmd_ready = 1'b1;
    send_search(12'h123);
    check("s1_valid", {31'b0, cmd_valid}, 32'd1);
    check("s1_write", {31'b0, cmd_write}, 32'd0);
    check("s1_data", {20'b0, cmd_data}, 32'h123);
    check("s1_addr", {28'b0, cmd_addr}, 32'd0);
    check("s1_nib_ready_hold", {31'b0, nib_ready}, 32'd0);
    tick();
    check("s1_valid_drop", {31'b0, cmd_valid}, 32'd0);
    check("s1_count", {24'b0, cmd_count}, 32'd1);
    check("s1_nib_ready_back", {31'b0, nib_ready}, 32'd1);

    // Write frame held by back-pressure; stray nibbles must be ignored
    cmd_ready = 1'b0;
    exp_q.push_back('{w: 1'b1, a: 4'h5, d: 12'hA0F});
    send_nib(4'h2);
    send_nib(4'h5);
    send_nib(4'hF);
    send_nib(4'h0);
    send_nib(4'hA);
    for (int i = 0; i < 10; i++) begin
      nib_valid = 1'b1;
      nib_data  = 4'h3;
      tick();
      check("w_hold_valid", {31'b0, cmd_valid}, 32'd1);
      check("w_hold_word", {15'b0, cmd_write, cmd_addr, cmd_data}, {15'b0, 1'b1, 4'h5, 12'hA0F});
      check("w_hold_nib_ready", {31'b0, nib_ready}, 32'd0);
    end
    nib_valid = 1'b0;
    cmd_ready = 1'b1;
    tick();
    check("w_valid_drop", {31'b0, cmd_valid}, 32'd0);
    check("w_count", {24'b0, cmd_count}, 32'd2);
    check("w_nib_ready", {31'b0, nib_ready}, 32'd1);

    // Bad opcode then a normal search
    send_nib(4'h7);
    check("bad_err_pulse", {31'b0, err_pulse}, 32'd1);
    check("bad_err_code", {30'b0, err_code}, 32'd1);
    tick();
    check("bad_err_pulse_drop", {31'b0, err_pulse}, 32'd0);
    check("bad_err_code_sticky", {30'b0, err_code}, 32'd1);
    send_search(12'h654);
    check("bad_next_valid", {31'b0, cmd_valid}, 32'd1);
    tick();
    check("bad_next_count", {24'b0, cmd_count}, 32'd3);

    // Stall timeout after 4 idle cycles
    send_nib(4'h1);
    send_nib(4'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_no_err_yet", {31'b0, err_pulse}, 32'd0);
    end
    tick();
    check("to_err_pulse", {31'b0, err_pulse}, 32'd1);
    check("to_err_code", {30'b0, err_code}, 32'd2);
    check("to_no_valid", {31'b0, cmd_valid}, 32'd0);
    tick();
    check("to_err_pulse_drop", {31'b0, err_pulse}, 32'd0);
    check("to_no_valid_later", {31'b0, cmd_valid}, 32'd0);

    // Nibble on the 4th idle cycle beats the timeout
    exp_q.push_back('{w: 1'b0, a: 4'h0, d: 12'hB98});
    send_nib(4'h1);
    send_nib(4'h8);
    repeat (3) tick();
    send_nib(4'h9);
    check("to_race_no_err", {31'b0, err_pulse}, 32'd0);
    send_nib(4'hB);
    check("to_race_valid", {31'b0, cmd_valid}, 32'd1);
    check("to_race_data", {20'b0, cmd_data}, 32'hB98);
    tick();
    check("to_race_count", {24'b0, cmd_count}, 32'd4);
    check("to_code_sticky", {30'b0, err_code}, 32'd2);

    // Reset mid-frame
    send_nib(4'h2);
    send_nib(4'h6);
    rst_n = 1'b0;
    #1;
    check("rm_addr", {28'b0, cmd_addr}, 32'd0);
    check("rm_write", {31'b0, cmd_write}, 32'd0);
    check("rm_count", {24'b0, cmd_count}, 32'd0);
    check("rm_err_code", {30'b0, err_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset during HOLD discards the pending command
    cmd_ready = 1'b0;
    send_nib(4'h1);
    send_nib(4'h1);
    send_nib(4'h2);
    send_nib(4'h3);
    check("rh_valid_before", {31'b0, cmd_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rh_valid", {31'b0, cmd_valid}, 32'd0);
    check("rh_data", {20'b0, cmd_data}, 32'd0);
    check("rh_nib_ready", {31'b0, nib_ready}, 32'd1);
    check("rh_count", {24'b0, cmd_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    repeat (3) tick();
    check("rh_no_valid_after", {31'b0, cmd_valid}, 32'd0);

    // 256 back-to-back searches wrap the counter
    cmd_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      send_search(12'($urandom_range(0, 4095)));
      if (i == 254) begin
        tick();
        check("wrap_count_255", {24'b0, cmd_count}, 32'd255);
      end
    end
    tick();
    check("wrap_count_0", {24'b0, cmd_count}, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
